// File: rtl/usb_wire_tx_driver.sv
// ---------------------------------------------------------------------------
// usb_wire_tx_driver
//
// Bit-rate pacing stage of the USB serial interface engine transmit path.
// Line-state symbols arrive one per write strobe and are buffered in a small
// FIFO. They are then played out to the transceiver pins one symbol per bit
// period. Each symbol carries its own rate: full speed lasts FS_DIV clocks and
// low speed lasts LS_DIV clocks. When the FIFO runs dry at a symbol boundary,
// the line is released.
//
// Optional feature: define USB_TX_UNDERRUN_DET_EN to enable sticky underrun
// detection. This covers a packet that ends without a release symbol. With the
// macro undefined, TxUnderrun is tied low.
//
// Parameters
//   FIFO_DEPTH            symbol FIFO entries, power of two, 2..16
//   FS_DIV                clocks per full-speed bit
//   LS_DIV                clocks per low-speed bit (<= 32)
//
// Ports
//   clk                   system clock, 48 MHz
//   rst                   synchronous active-high reset
//   USBWireData   [1:0]   symbol line state {D+, D-}
//   USBWireCtrl           1 = drive the line during this symbol
//   USBWireFullSpeedRate  rate of the symbol being written (1 = FS, 0 = LS)
//   USBWireWEn            write strobe, one-cycle pulse per symbol
//   USBWireRdy            FIFO can accept a symbol this cycle
//   TxBitsOut     [1:0]   line state to the transceiver
//   TxOE                  transceiver output enable (1 = drive)
//   TxWireActive          high while a symbol is being timed out
//   TxUnderrun            sticky underrun flag
// ---------------------------------------------------------------------------
module usb_wire_tx_driver #(
    parameter int FIFO_DEPTH = 4,
    parameter int FS_DIV     = 4,
    parameter int LS_DIV     = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] USBWireData,
    input  logic       USBWireCtrl,
    input  logic       USBWireFullSpeedRate,
    input  logic       USBWireWEn,
    output logic       USBWireRdy,
    output logic [1:0] TxBitsOut,
    output logic       TxOE,
    output logic       TxWireActive,
    output logic       TxUnderrun
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
    localparam logic [4:0]       FS_LOAD  = 5'(FS_DIV - 1);
    localparam logic [4:0]       LS_LOAD  = 5'(LS_DIV - 1);

    typedef struct packed {
        logic       rate;
        logic       ctrl;
        logic [1:0] data;
    } sym_t;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    sym_t             mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    state_t           state;
    logic [4:0]       bit_cnt;

    logic push;
    logic pop;
    sym_t head;
    sym_t wr_sym;

    // Ready comes from the registered count only. A write strobe never feeds
    // back into its own acceptance.
    assign USBWireRdy = (count != FULL_CNT);
    assign push       = USBWireWEn && USBWireRdy;
    assign head       = mem[rd_ptr];
    assign wr_sym     = '{rate: USBWireFullSpeedRate, ctrl: USBWireCtrl, data: USBWireData};

    // A symbol is taken from the FIFO either to start a packet from idle, or at
    // the boundary where the current symbol's period has expired.
    assign pop = (count != '0) && ((state == IDLE) || (bit_cnt == '0));

    // NOTE: the storage array has no reset. Its contents are meaningless until
    // count says otherwise, so clearing it would only add reset fan-out.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_sym;
        end
    end

    // Pointers wrap naturally because FIFO_DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: all state and outputs here use non-blocking assignments. Each
    // branch can then read the pre-edge bit_cnt/state values without any
    // dependence on statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            bit_cnt      <= '0;
            TxBitsOut    <= 2'b00;
            TxOE         <= 1'b0;
            TxWireActive <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        TxBitsOut    <= head.data;
                        TxOE         <= head.ctrl;
                        bit_cnt      <= head.rate ? FS_LOAD : LS_LOAD;
                        TxWireActive <= 1'b1;
                        state        <= ACTIVE;
                    end
                end
                ACTIVE: begin
                    if (bit_cnt != '0) begin
                        bit_cnt <= bit_cnt - 1'b1;
                    end else if (pop) begin
                        // Seamless hand-over. The next symbol's own rate sets
                        // its period.
                        TxBitsOut <= head.data;
                        TxOE      <= head.ctrl;
                        bit_cnt   <= head.rate ? FS_LOAD : LS_LOAD;
                    end else begin
                        // Drained: release the line and keep the last line
                        // state on the pins.
                        TxOE         <= 1'b0;
                        TxWireActive <= 1'b0;
                        state        <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef USB_TX_UNDERRUN_DET_EN
    logic underrun;

    // TxOE still holds the ctrl bit of the last popped symbol. If that bit is
    // set when the FIFO drains, the packet never sent its release symbol.
    always_ff @(posedge clk) begin
        if (rst) begin
            underrun <= 1'b0;
        end else if ((state == ACTIVE) && (bit_cnt == '0) && (count == '0) && TxOE) begin
            underrun <= 1'b1;
        end
    end

    assign TxUnderrun = underrun;
`else
    assign TxUnderrun = 1'b0;
`endif

endmodule
